// File: rtl/pearson_pkg.sv
// Shared types, the Pearson permutation table and the single-round helper
// used by the Pearson hash engine and its testbench.
package pearson_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HASH = 2'd1,
      DONE = 2'd2
   } pearson_state_t;

   // Affine permutation T[i] = (3*i + 7) mod 256 with entries 172 and 212 exchanged.
   localparam logic [7:0] PEARSON_T [0:255] = '{
      8'd7,   8'd10,  8'd13,  8'd16,  8'd19,  8'd22,  8'd25,  8'd28,  8'd31,  8'd34,  8'd37,  8'd40,  8'd43,  8'd46,  8'd49,  8'd52,
      8'd55,  8'd58,  8'd61,  8'd64,  8'd67,  8'd70,  8'd73,  8'd76,  8'd79,  8'd82,  8'd85,  8'd88,  8'd91,  8'd94,  8'd97,  8'd100,
      8'd103, 8'd106, 8'd109, 8'd112, 8'd115, 8'd118, 8'd121, 8'd124, 8'd127, 8'd130, 8'd133, 8'd136, 8'd139, 8'd142, 8'd145, 8'd148,
      8'd151, 8'd154, 8'd157, 8'd160, 8'd163, 8'd166, 8'd169, 8'd172, 8'd175, 8'd178, 8'd181, 8'd184, 8'd187, 8'd190, 8'd193, 8'd196,
      8'd199, 8'd202, 8'd205, 8'd208, 8'd211, 8'd214, 8'd217, 8'd220, 8'd223, 8'd226, 8'd229, 8'd232, 8'd235, 8'd238, 8'd241, 8'd244,
      8'd247, 8'd250, 8'd253, 8'd0,   8'd3,   8'd6,   8'd9,   8'd12,  8'd15,  8'd18,  8'd21,  8'd24,  8'd27,  8'd30,  8'd33,  8'd36,
      8'd39,  8'd42,  8'd45,  8'd48,  8'd51,  8'd54,  8'd57,  8'd60,  8'd63,  8'd66,  8'd69,  8'd72,  8'd75,  8'd78,  8'd81,  8'd84,
      8'd87,  8'd90,  8'd93,  8'd96,  8'd99,  8'd102, 8'd105, 8'd108, 8'd111, 8'd114, 8'd117, 8'd120, 8'd123, 8'd126, 8'd129, 8'd132,
      8'd135, 8'd138, 8'd141, 8'd144, 8'd147, 8'd150, 8'd153, 8'd156, 8'd159, 8'd162, 8'd165, 8'd168, 8'd171, 8'd174, 8'd177, 8'd180,
      8'd183, 8'd186, 8'd189, 8'd192, 8'd195, 8'd198, 8'd201, 8'd204, 8'd207, 8'd210, 8'd213, 8'd216, 8'd219, 8'd222, 8'd225, 8'd228,
      8'd231, 8'd234, 8'd237, 8'd240, 8'd243, 8'd246, 8'd249, 8'd252, 8'd255, 8'd2,   8'd5,   8'd8,   8'd131, 8'd14,  8'd17,  8'd20,
      8'd23,  8'd26,  8'd29,  8'd32,  8'd35,  8'd38,  8'd41,  8'd44,  8'd47,  8'd50,  8'd53,  8'd56,  8'd59,  8'd62,  8'd65,  8'd68,
      8'd71,  8'd74,  8'd77,  8'd80,  8'd83,  8'd86,  8'd89,  8'd92,  8'd95,  8'd98,  8'd101, 8'd104, 8'd107, 8'd110, 8'd113, 8'd116,
      8'd119, 8'd122, 8'd125, 8'd128, 8'd11,  8'd134, 8'd137, 8'd140, 8'd143, 8'd146, 8'd149, 8'd152, 8'd155, 8'd158, 8'd161, 8'd164,
      8'd167, 8'd170, 8'd173, 8'd176, 8'd179, 8'd182, 8'd185, 8'd188, 8'd191, 8'd194, 8'd197, 8'd200, 8'd203, 8'd206, 8'd209, 8'd212,
      8'd215, 8'd218, 8'd221, 8'd224, 8'd227, 8'd230, 8'd233, 8'd236, 8'd239, 8'd242, 8'd245, 8'd248, 8'd251, 8'd254, 8'd1,   8'd4
   };

   function automatic logic [7:0] pearson_round(input logic [7:0] h, input logic [7:0] b);
      return PEARSON_T[h ^ b];
   endfunction

endpackage

// File: rtl/pearson_seq_ctrl_lut.sv
// Single shared Pearson table lookup: purely combinational 8-bit address to 8-bit value.
module pearson_round_lut
   import pearson_pkg::*;
(
   input  logic [7:0] addr,
   output logic [7:0] data
);

   assign data = PEARSON_T[addr];

endmodule

// File: rtl/pearson_seq_ctrl.sv
// Byte-serial Pearson hash engine: one table round per clock through a single shared lookup.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid must hold until then.
module pearson_seq_ctrl
   import pearson_pkg::*;
#(
   parameter int         KEY_BYTES = 8,
   parameter logic [7:0] INIT_HASH = 8'h00,
   parameter int         LEN_W     = 4
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [8*KEY_BYTES-1:0] in_key,
   input  logic [LEN_W-1:0]       in_len,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [7:0]             out_hash,
   output logic                   busy,
   output pearson_state_t         dbg_state
);

   localparam int               IDX_W   = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(KEY_BYTES);

   pearson_state_t         state, next_state;
   logic [8*KEY_BYTES-1:0] key_q;
   logic [LEN_W-1:0]       len_q, eff_len;
   logic [IDX_W-1:0]       idx_q;
   logic [7:0]             h_q, hash_q, key_byte, lut_addr, lut_data;
   logic                   accept, last_byte;

   pearson_round_lut u_lut (
      .addr (lut_addr),
      .data (lut_data)
   );

   always_comb begin
      eff_len = in_len;
      if (in_len == '0 || in_len > MAX_LEN) eff_len = MAX_LEN;
   end

   always_comb begin
      key_byte = '0;
      for (int i = 0; i < KEY_BYTES; i++) begin
         if (idx_q == IDX_W'(i)) key_byte = key_q[8*i +: 8];
      end
   end

   assign lut_addr  = h_q ^ key_byte;
   assign last_byte = (LEN_W'(idx_q) == len_q - LEN_W'(1));
   assign accept    = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) next_state = HASH;
         end
         HASH: begin
            busy = 1'b1;
            if (last_byte) next_state = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // idx holds at len-1 on the final round so it never wraps.
   always_ff @(posedge clk) begin
      if (rst) begin
         key_q  <= '0;
         len_q  <= '0;
         idx_q  <= '0;
         h_q    <= '0;
         hash_q <= '0;
      end else if (accept) begin
         key_q <= in_key;
         len_q <= eff_len;
         idx_q <= '0;
         h_q   <= INIT_HASH;
      end else if (state == HASH) begin
         h_q <= lut_data;
         if (last_byte) hash_q <= lut_data;
         else           idx_q  <= idx_q + IDX_W'(1);
      end
   end

   assign out_hash  = hash_q;
   assign dbg_state = state;

endmodule

// File: tb/tb_pearson_seq_ctrl.sv
// Self-checking bench for pearson_seq_ctrl against a loop-based Pearson hash model.
module tb_pearson_seq_ctrl;
   import pearson_pkg::*;

   localparam int         KB   = 8;
   localparam int         LW   = 4;
   localparam logic [7:0] INIT = 8'h00;
   localparam logic [63:0] KEY_HELLO = {8'd104, 8'd101, 8'd108, 8'd108, 8'd111, 8'd104, 8'd101, 8'd108};

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [8*KB-1:0] in_key;
   logic [LW-1:0]   in_len;
   logic            out_valid;
   logic            out_ready;
   logic [7:0]      out_hash;
   logic            busy;
   pearson_state_t  dbg_state;

   int total = 0;
   int bad   = 0;
   int edges = 0;

   pearson_seq_ctrl #(.KEY_BYTES(KB), .INIT_HASH(INIT), .LEN_W(LW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_key    (in_key),
      .in_len    (in_len),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_hash  (out_hash),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edges <= edges + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int eff_len(input int l);
      return (l == 0 || l > KB) ? KB : l;
   endfunction

   function automatic logic [7:0] model_hash(input logic [63:0] key, input int l);
      logic [7:0] h = INIT;
      for (int i = 0; i < eff_len(l); i++) h = pearson_round(h, key[8*i +: 8]);
      return h;
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic [63:0] k, input logic [LW-1:0] l, output int acc);
      bit got = 0;
      in_valid = 1'b1;
      in_key   = k;
      in_len   = l;
      acc      = -1;
      for (int i = 0; i < 50 && !got; i++) begin
         if (in_ready) got = 1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      total++;
      if (!got) begin
         bad++;
         $display("FAIL send_timeout: in_ready never seen, required 1");
      end else acc = edges;
   endtask

   task automatic wait_out(output int at, output logic [7:0] h);
      bit got = 0;
      at = -1;
      h  = 8'h00;
      for (int i = 0; i < 40 && !got; i++) begin
         if (out_valid) begin
            got = 1;
            at  = edges;
            h   = out_hash;
         end else @(negedge clk);
      end
      total++;
      if (!got) begin
         bad++;
         $display("FAIL out_timeout: out_valid never seen, required 1");
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_key = '0; in_len = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total += 5;
      if (in_ready !== 1'b1)   begin bad++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
      if (out_valid !== 1'b0)  begin bad++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
      if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
      if (out_hash !== 8'h00)  begin bad++; $display("FAIL reset_out_hash: got %0d want 0", out_hash); end
      if (dbg_state !== IDLE)  begin bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
   endtask

   task automatic test_single();
      int acc, at; logic [7:0] h;
      out_ready = 1'b1;
      send(KEY_HELLO, 4'd8, acc);
      wait_out(at, h);
      total += 3;
      if (at - acc !== 8)  begin bad++; $display("FAIL single_latency: got %0d want 8", at - acc); end
      if (h !== 8'd131)    begin bad++; $display("FAIL single_hash: got %0d want 131", h); end
      @(negedge clk);
      if (in_ready !== 1'b1) begin bad++; $display("FAIL single_return_idle: in_ready got %0b want 1", in_ready); end
   endtask

   task automatic test_short();
      int acc, at; logic [7:0] h;
      out_ready = 1'b1;
      send(64'h0, 4'd1, acc);
      wait_out(at, h);
      total += 2;
      if (at - acc !== 1)              begin bad++; $display("FAIL short_latency: got %0d want 1", at - acc); end
      if (h !== PEARSON_T[INIT])       begin bad++; $display("FAIL short_hash: got %0d want %0d", h, PEARSON_T[INIT]); end
      @(negedge clk);
      send(KEY_HELLO, 4'd0, acc);
      wait_out(at, h);
      total += 2;
      if (at - acc !== 8)  begin bad++; $display("FAIL len0_latency: got %0d want 8", at - acc); end
      if (h !== 8'd131)    begin bad++; $display("FAIL len0_hash: got %0d want 131", h); end
      @(negedge clk);
      send(KEY_HELLO, 4'd13, acc);
      wait_out(at, h);
      total++;
      if (h !== 8'd131)    begin bad++; $display("FAIL clamp_hash: got %0d want 131", h); end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int acc, at; logic [7:0] h, held;
      logic [63:0] k1, k2; logic [LW-1:0] l1, l2;
      k1 = {$urandom, $urandom}; l1 = LW'($urandom_range(1, 8));
      k2 = {$urandom, $urandom}; l2 = LW'($urandom_range(0, 15));
      out_ready = 1'b0;
      send(k1, l1, acc);
      wait_out(at, held);
      total++;
      if (held !== model_hash(k1, int'(l1))) begin bad++; $display("FAIL bp_hash: got %0d want %0d", held, model_hash(k1, int'(l1))); end
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_key = k2; in_len = l2;
         @(negedge clk);
         total += 3;
         if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid: got %0b want 1", out_valid); end
         if (out_hash !== held)  begin bad++; $display("FAIL bp_out_hash: got %0d want %0d", out_hash, held); end
         if (in_ready !== 1'b0)  begin bad++; $display("FAIL bp_in_ready: got %0b want 0", in_ready); end
      end
      out_ready = 1'b1;
      @(negedge clk);
      total += 2;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid: got %0b want 0", out_valid); end
      if (in_ready !== 1'b1)  begin bad++; $display("FAIL bp_release_idle: got %0b want 1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL bp_next_accept: busy got %0b want 1", busy); end
      wait_out(at, h);
      total++;
      if (h !== model_hash(k2, int'(l2))) begin bad++; $display("FAIL bp_second_hash: got %0d want %0d", h, model_hash(k2, int'(l2))); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int acc, at; logic [7:0] h; bit seen = 0;
      out_ready = 1'b1;
      send(KEY_HELLO, 4'd8, acc);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total += 4;
      if (in_ready !== 1'b1)  begin bad++; $display("FAIL midrst_in_ready: got %0b want 1", in_ready); end
      if (busy !== 1'b0)      begin bad++; $display("FAIL midrst_busy: got %0b want 0", busy); end
      if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid: got %0b want 0", out_valid); end
      if (out_hash !== 8'h00) begin bad++; $display("FAIL midrst_out_hash: got %0d want 0", out_hash); end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1;
      end
      total++;
      if (seen) begin bad++; $display("FAIL midrst_no_pulse: out_valid got 1 want 0"); end
      send(KEY_HELLO, 4'd8, acc);
      wait_out(at, h);
      total++;
      if (h !== 8'd131) begin bad++; $display("FAIL midrst_next_hash: got %0d want 131", h); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int acc, at, prev_acc, prev_len; logic [7:0] h;
      logic [63:0] k; logic [LW-1:0] l;
      out_ready = 1'b1;
      prev_acc = 0; prev_len = 0;
      for (int n = 0; n < 4; n++) begin
         k = {$urandom, $urandom};
         l = LW'($urandom_range(0, 15));
         send(k, l, acc);
         if (n > 0) begin
            total++;
            if (acc - prev_acc !== eff_len(prev_len) + 2) begin
               bad++;
               $display("FAIL b2b_spacing: got %0d want %0d", acc - prev_acc, eff_len(prev_len) + 2);
            end
         end
         wait_out(at, h);
         total++;
         if (h !== model_hash(k, int'(l))) begin bad++; $display("FAIL b2b_hash: got %0d want %0d", h, model_hash(k, int'(l))); end
         prev_acc = acc;
         prev_len = int'(l);
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_key = '0; in_len = '0;
      @(negedge clk);
      test_reset();
      test_single();
      test_short();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
